// File: rtl/mcs4_clock_gen_pkg.sv
// Shared MCS-4 timing constants, halt-control state type and the window decode helper.
// The i4004 and bus benches import the same defaults so every block agrees on the clock.
package mcs4_clock_gen_pkg;

    localparam int unsigned DEF_PERIOD     = 68;
    localparam int unsigned DEF_CLK1_START = 0;
    localparam int unsigned DEF_CLK1_WIDTH = 20;
    localparam int unsigned DEF_CLK2_START = 34;
    localparam int unsigned DEF_CLK2_WIDTH = 20;
    localparam int unsigned DEF_POC_CYCLES = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_t;

    function automatic logic in_window(input int unsigned value,
                                       input int unsigned start,
                                       input int unsigned width);
        return (value >= start) && (value < start + width);
    endfunction

endpackage

// File: rtl/mcs4_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; both flops clear to 0 on reset.
module mcs4_sync2 (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mcs4_clock_gen.sv
// MCS-4 two-phase non-overlapping clock, power-on-clear and cycle-boundary halt control.
// Every output comes straight from a flop so the chip clock pads never see decode glitches.
module mcs4_clock_gen
    import mcs4_clock_gen_pkg::*;
#(
    parameter int unsigned PERIOD     = DEF_PERIOD,
    parameter int unsigned CLK1_START = DEF_CLK1_START,
    parameter int unsigned CLK1_WIDTH = DEF_CLK1_WIDTH,
    parameter int unsigned CLK2_START = DEF_CLK2_START,
    parameter int unsigned CLK2_WIDTH = DEF_CLK2_WIDTH,
    parameter int unsigned POC_CYCLES = DEF_POC_CYCLES
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic poc_req,
    input  logic halt,
    output logic clk1,
    output logic clk2,
    output logic poc,
    output logic halted,
    output logic cycle_strobe
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned PW = (POC_CYCLES > 1) ? $clog2(POC_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [PW-1:0] POC_LAST = PW'(POC_CYCLES - 1);

    // Windows must sit inside the period, clk1 first, with an idle tick on both sides incl. the wrap.
    localparam bit PARAMS_OK =
        (PERIOD >= 2) && (CLK1_WIDTH >= 1) && (CLK2_WIDTH >= 1) && (POC_CYCLES >= 1) &&
        (CLK1_START + CLK1_WIDTH <= PERIOD) && (CLK2_START + CLK2_WIDTH <= PERIOD) &&
        (CLK1_START + CLK1_WIDTH < CLK2_START) &&
        (CLK2_START + CLK2_WIDTH < CLK1_START + PERIOD);

    if (!PARAMS_OK) begin : g_bad_params
        $error("mcs4_clock_gen: clock windows overlap, leave no gap, or POC_CYCLES is 0");
    end

    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       poc_req_s;
    logic       halt_s;

    assign async_in = {halt, poc_req};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        mcs4_sync2 u_sync (
            .sysclk   (sysclk),
            .sysrst_n (sysrst_n),
            .d        (async_in[gi]),
            .q        (sync_out[gi])
        );
    end

    assign poc_req_s = sync_out[0];
    assign halt_s    = sync_out[1];

    run_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          clk1_reg, clk1_next;
    logic          clk2_reg, clk2_next;
    logic          strobe_reg, strobe_next;
    logic          poc_reg, poc_next;
    logic [PW-1:0] poc_cnt_reg, poc_cnt_next;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            clk1_reg    <= 1'b0;
            clk2_reg    <= 1'b0;
            strobe_reg  <= 1'b0;
            poc_reg     <= 1'b1;
            poc_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            clk1_reg    <= clk1_next;
            clk2_reg    <= clk2_next;
            strobe_reg  <= strobe_next;
            poc_reg     <= poc_next;
            poc_cnt_reg <= poc_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        strobe_next = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    strobe_next = 1'b1;
                    if (halt_s) begin
                        state_next = ST_HALTED;
                    end else begin
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HALTED: begin
                if (!halt_s) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
        endcase

        // Hold both phases low on the halt-entry tick, while frozen, and on the resume tick.
        clk1_next = (state_reg == ST_RUN) && (state_next == ST_RUN) &&
                    in_window(32'(cnt_reg), CLK1_START, CLK1_WIDTH);
        clk2_next = (state_reg == ST_RUN) && (state_next == ST_RUN) &&
                    in_window(32'(cnt_reg), CLK2_START, CLK2_WIDTH);

        poc_next     = poc_reg;
        poc_cnt_next = poc_cnt_reg;
        if (poc_req_s) begin
            poc_next     = 1'b1;
            poc_cnt_next = '0;
        end else if (poc_reg && strobe_reg) begin
            if (poc_cnt_reg == POC_LAST) begin
                poc_next     = 1'b0;
                poc_cnt_next = '0;
            end else begin
                poc_cnt_next = poc_cnt_reg + 1'b1;
            end
        end
    end

    assign clk1         = clk1_reg;
    assign clk2         = clk2_reg;
    assign poc          = poc_reg;
    assign cycle_strobe = strobe_reg;
    assign halted       = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_mcs4_clock_gen.sv
// Randomised self-checking bench for mcs4_clock_gen: expected waveforms come from
// tick arithmetic relative to the last point the phase counter was at 0.
module tb_mcs4_clock_gen;

    localparam int P      = 68;
    localparam int C1_S   = 0;
    localparam int C1_W   = 20;
    localparam int C2_S   = 34;
    localparam int C2_W   = 20;
    localparam int POC_N  = 16;

    logic sysclk;
    logic sysrst_n;
    logic poc_req;
    logic halt;
    logic clk1;
    logic clk2;
    logic poc;
    logic halted;
    logic cycle_strobe;

    int checks;
    int errors;
    int tick;   // posedges since reset release
    int base;   // edge after which the phase counter was 0

    mcs4_clock_gen dut (
        .sysclk       (sysclk),
        .sysrst_n     (sysrst_n),
        .poc_req      (poc_req),
        .halt         (halt),
        .clk1         (clk1),
        .clk2         (clk2),
        .poc          (poc),
        .halted       (halted),
        .cycle_strobe (cycle_strobe)
    );

    initial begin
        sysclk = 1'b0;
        forever #10 sysclk = ~sysclk;
    end

    initial begin
        #(200_000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase that was decoded to produce the outputs seen after edge e.
    function automatic int phase_of(int e);
        return (e - base - 1) % P;
    endfunction

    function automatic logic exp_clk1(int e);
        if (e <= base) return 1'b0;
        return (phase_of(e) >= C1_S) && (phase_of(e) < C1_S + C1_W);
    endfunction

    function automatic logic exp_clk2(int e);
        if (e <= base) return 1'b0;
        return (phase_of(e) >= C2_S) && (phase_of(e) < C2_S + C2_W);
    endfunction

    function automatic logic exp_strobe(int e);
        return (e > base) && (((e - base) % P) == 0);
    endfunction

    task automatic step();
        @(posedge sysclk);
        #1;
        tick++;
    endtask

    task automatic release_reset();
        @(posedge sysclk);
        #1;
        sysrst_n = 1'b1;
        tick = 0;
        base = 0;
    endtask

    task automatic test_reset();
        sysrst_n = 1'b0;
        poc_req  = 1'b0;
        halt     = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        checks += 5;
        if (clk1 !== 1'b0)         begin errors++; $display("FAIL reset_clk1 got=%b exp=0", clk1); end
        if (clk2 !== 1'b0)         begin errors++; $display("FAIL reset_clk2 got=%b exp=0", clk2); end
        if (poc !== 1'b1)          begin errors++; $display("FAIL reset_poc got=%b exp=1", poc); end
        if (halted !== 1'b0)       begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        if (cycle_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", cycle_strobe); end
        $display("reset: clk1=%b clk2=%b poc=%b halted=%b strobe=%b", clk1, clk2, poc, halted, cycle_strobe);
        release_reset();
    endtask

    // Power-up: clock windows every period and poc falling after POC_N full cycles.
    task automatic test_free_run();
        int poc_fall;
        poc_fall = POC_N * P + 1;
        while (tick < poc_fall + 10) begin
            step();
            checks += 5;
            if (clk1 !== exp_clk1(tick))
                begin errors++; $display("FAIL run_clk1 tick=%0d got=%b exp=%b", tick, clk1, exp_clk1(tick)); end
            if (clk2 !== exp_clk2(tick))
                begin errors++; $display("FAIL run_clk2 tick=%0d got=%b exp=%b", tick, clk2, exp_clk2(tick)); end
            if (cycle_strobe !== exp_strobe(tick))
                begin errors++; $display("FAIL run_strobe tick=%0d got=%b exp=%b", tick, cycle_strobe, exp_strobe(tick)); end
            if (clk1 === 1'b1 && clk2 === 1'b1)
                begin errors++; $display("FAIL run_overlap tick=%0d clk1=%b clk2=%b", tick, clk1, clk2); end
            if (poc !== (tick < poc_fall))
                begin errors++; $display("FAIL run_poc tick=%0d got=%b exp=%b", tick, poc, tick < poc_fall); end
            if (tick == poc_fall - 1) begin
                checks++;
                if (clk1 !== 1'b0 || clk2 !== 1'b0)
                    begin errors++; $display("FAIL poc_fall_clocks tick=%0d clk1=%b clk2=%b exp=00", tick, clk1, clk2); end
            end
        end
        $display("free_run: checked ticks 1..%0d, poc expected to fall at tick %0d", tick, poc_fall);
    endtask

    task automatic test_poc_req();
        int a, b, m, fall;
        a = 30 * P + int'($urandom_range(0, P - 1));
        b = a + int'($urandom_range(0, 2));
        m = ((b + 2 + P - 1) / P) * P;
        fall = m + (POC_N - 1) * P + 1;
        while (tick < fall + 10) begin
            step();
            poc_req = (tick + 1 >= a) && (tick + 1 <= b);
            checks += 3;
            if (poc !== ((tick >= a + 2) && (tick < fall)))
                begin errors++; $display("FAIL pocreq_poc tick=%0d got=%b exp=%b", tick, poc, (tick >= a + 2) && (tick < fall)); end
            if (clk1 !== exp_clk1(tick))
                begin errors++; $display("FAIL pocreq_clk1 tick=%0d got=%b exp=%b", tick, clk1, exp_clk1(tick)); end
            if (clk2 !== exp_clk2(tick))
                begin errors++; $display("FAIL pocreq_clk2 tick=%0d got=%b exp=%b", tick, clk2, exp_clk2(tick)); end
        end
        $display("poc_req: pulse ticks %0d..%0d, poc expected high %0d..%0d", a, b, a + 2, fall - 1);
    endtask

    // Halt raised at phase r freezes at the end of that cycle; resume re-bases the phase.
    task automatic test_halt(int r, int hold);
        int tick_r, e_entry, h_drop, resume, stop_at;
        logic x1, x2, xs, xh;
        tick_r  = tick + 1 + ((r - ((tick + 1 - base) % P) + P) % P);
        e_entry = tick_r + (P - 1 - r) + 1;
        h_drop  = e_entry + hold;
        resume  = h_drop + 3;
        stop_at = resume + P + 5;
        while (tick < stop_at) begin
            step();
            halt = (tick >= tick_r) && (tick < h_drop);
            if (tick == resume) base = resume;
            if (tick < e_entry || tick >= resume) begin
                x1 = exp_clk1(tick);
                x2 = exp_clk2(tick);
                xs = exp_strobe(tick);
                xh = 1'b0;
            end else begin
                x1 = 1'b0;
                x2 = 1'b0;
                xs = (tick == e_entry);
                xh = 1'b1;
            end
            checks += 5;
            if (clk1 !== x1)         begin errors++; $display("FAIL halt_clk1 tick=%0d got=%b exp=%b", tick, clk1, x1); end
            if (clk2 !== x2)         begin errors++; $display("FAIL halt_clk2 tick=%0d got=%b exp=%b", tick, clk2, x2); end
            if (cycle_strobe !== xs) begin errors++; $display("FAIL halt_strobe tick=%0d got=%b exp=%b", tick, cycle_strobe, xs); end
            if (halted !== xh)       begin errors++; $display("FAIL halt_halted tick=%0d got=%b exp=%b", tick, halted, xh); end
            if (poc !== 1'b0)        begin errors++; $display("FAIL halt_poc tick=%0d got=%b exp=0", tick, poc); end
        end
        $display("halt: raised at phase %0d, entry tick %0d, dropped tick %0d, resume tick %0d", r, e_entry, h_drop, resume);
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (!exp_clk2(tick) && budget < 2 * P) begin
            step();
            budget++;
        end
        checks++;
        if (clk2 !== 1'b1) begin errors++; $display("FAIL arst_pre_clk2 tick=%0d got=%b exp=1", tick, clk2); end
        #4;
        sysrst_n = 1'b0;
        #1;
        checks += 3;
        if (clk2 !== 1'b0)   begin errors++; $display("FAIL arst_clk2 got=%b exp=0", clk2); end
        if (clk1 !== 1'b0)   begin errors++; $display("FAIL arst_clk1 got=%b exp=0", clk1); end
        if (poc !== 1'b1)    begin errors++; $display("FAIL arst_poc got=%b exp=1", poc); end
        $display("async_reset running: clk1=%b clk2=%b poc=%b", clk1, clk2, poc);
        release_reset();

        halt = 1'b1;
        budget = 0;
        while (halted !== 1'b1 && budget < 3 * P) begin
            step();
            budget++;
        end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL arst_halt_entry got=%b exp=1 after %0d ticks", halted, budget); end
        #4;
        sysrst_n = 1'b0;
        #1;
        checks += 3;
        if (halted !== 1'b0) begin errors++; $display("FAIL arst_halted got=%b exp=0", halted); end
        if (poc !== 1'b1)    begin errors++; $display("FAIL arst_halted_poc got=%b exp=1", poc); end
        if (clk1 !== 1'b0)   begin errors++; $display("FAIL arst_halted_clk1 got=%b exp=0", clk1); end
        $display("async_reset halted: halted=%b poc=%b", halted, poc);
        halt = 1'b0;
        release_reset();
    endtask

    task automatic test_back_to_back();
        while (tick < 2 * P + 3) begin
            step();
            checks += 3;
            if (clk1 !== exp_clk1(tick)) begin errors++; $display("FAIL b2b_clk1 tick=%0d got=%b exp=%b", tick, clk1, exp_clk1(tick)); end
            if (clk2 !== exp_clk2(tick)) begin errors++; $display("FAIL b2b_clk2 tick=%0d got=%b exp=%b", tick, clk2, exp_clk2(tick)); end
            if (poc !== 1'b1)            begin errors++; $display("FAIL b2b_poc tick=%0d got=%b exp=1", tick, poc); end
        end
        $display("back_to_back: restart after reset checked for %0d ticks", tick);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tick   = 0;
        base   = 0;
        test_reset();
        test_free_run();
        test_poc_req();
        test_halt(10, 12);
        test_halt(int'($urandom_range(0, 60)), int'($urandom_range(3, 30)));
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
